load_store_unit: RTL and testbench

//   Sits between the RV32I execute stage and data_memory, which only does whole-word

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/load_store_unit_if.sv | 28 ++
 rtl/lsu_load_align.sv | 38 +++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings, the
// controller state type, access sizes and small decode helpers.
package lsu_pkg;

  // RV32I load/store funct3 encodings (stores reuse F3_B/F3_H/F3_W).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    RESP     = 3'd4
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Access size from funct3; the low two bits carry the size for loads and stores.
  function automatic lsu_size_t size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = SZ_B;
      2'b01:   size_of = SZ_H;
      default: size_of = SZ_W;
    endcase
  endfunction

  // Illegal funct3: loads reject 011/110/111, stores reject anything with bit 2 set.
  function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
    if (we) begin
      f3_illegal = funct3[2];
    end else begin
      case (funct3)
        3'b011, 3'b110, 3'b111: f3_illegal = 1'b1;
        default:                f3_illegal = 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bundle between the execute stage (master) and the
// load/store unit (slave).
//   req_valid/req_ready  request handshake
//   req_we/funct3/addr/wdata  request fields
//   rsp_valid            one-cycle response pulse, no backpressure
//   rsp_rdata/misaligned/fault  response fields, meaningful only with rsp_valid
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault
  );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load alignment: picks the byte/halfword lane addressed by
// addr_lo out of a little-endian memory word and sign- or zero-extends it.
//   word    in  32  word read from memory
//   addr_lo in  2   low byte-address bits
//   funct3  in  3   load funct3
//   value   out 32  extended result (0 for an unknown funct3)
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    half_s = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    value = {{24{byte_s[7]}}, byte_s};
      F3_H:    value = {{16{half_s[15]}}, half_s};
      F3_W:    value = word;
      F3_BU:   value = {24'h000000, byte_s};
      F3_HU:   value = {16'h0000, half_s};
      default: value = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide data memory with a
// combinational read. Loads are aligned and extended, sub-word stores are
// done as read-modify-write, and bad accesses are answered without touching
// memory.
//   clk, rst                  clock, asynchronous active-high reset
//   bus (slave)               request/response handshake
//   mem_write_en/address/data_in  to data memory
//   mem_data_out              combinational read data from data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  load_store_unit_if.slave      bus,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_in,
  input  logic [31:0]           mem_data_out
);

  lsu_state_t            state_r;
  lsu_state_t            state_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [2:0]            funct3_r;
  logic [31:0]           data_r;     // store data, later the merged RMW word
  logic [31:0]           rdata_r;
  logic                  mis_r;
  logic                  fault_r;

  logic                  accept_s;
  logic                  fault_s;
  logic                  mis_s;
  lsu_size_t             req_size_s;
  logic [31:0]           load_val_s;
  logic [31:0]           merged_s;

  assign accept_s = bus.req_valid && (state_r == IDLE);

  // Error classification of the offered request; fault outranks misalignment.
  always_comb begin
    req_size_s = size_of(bus.req_funct3);
    fault_s    = f3_illegal(bus.req_we, bus.req_funct3) ||
                 (bus.req_addr[31:ADDR_WIDTH] != {(32-ADDR_WIDTH){1'b0}});
    if (fault_s) begin
      mis_s = 1'b0;
    end else begin
      case (req_size_s)
        SZ_H:    mis_s = bus.req_addr[0];
        SZ_W:    mis_s = (bus.req_addr[1:0] != 2'b00);
        default: mis_s = 1'b0;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s)                 state_nxt_s = IDLE;
        else if (fault_s || mis_s)     state_nxt_s = RESP;
        else if (!bus.req_we)          state_nxt_s = LOAD;
        else if (req_size_s == SZ_W)   state_nxt_s = WRITE;
        else                           state_nxt_s = RMW_READ;
      end
      LOAD:     state_nxt_s = RESP;
      RMW_READ: state_nxt_s = WRITE;
      WRITE:    state_nxt_s = RESP;
      RESP:     state_nxt_s = IDLE;
      default:  state_nxt_s = IDLE;
    endcase
  end

  lsu_load_align u_load_align (
    .word    (mem_data_out),
    .addr_lo (addr_r[1:0]),
    .funct3  (funct3_r),
    .value   (load_val_s)
  );

  // Sub-word store merge: overwrite the addressed lane(s), keep the rest.
  always_comb begin
    merged_s = mem_data_out;
    if (size_of(funct3_r) == SZ_H) begin
      if (addr_r[1]) merged_s[31:16] = data_r[15:0];
      else           merged_s[15:0]  = data_r[15:0];
    end else begin
      case (addr_r[1:0])
        2'd0:    merged_s[7:0]   = data_r[7:0];
        2'd1:    merged_s[15:8]  = data_r[7:0];
        2'd2:    merged_s[23:16] = data_r[7:0];
        default: merged_s[31:24] = data_r[7:0];
      endcase
    end
  end

  // State register and datapath capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      addr_r   <= {ADDR_WIDTH{1'b0}};
      funct3_r <= 3'b000;
      data_r   <= 32'h0000_0000;
      rdata_r  <= 32'h0000_0000;
      mis_r    <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            addr_r   <= bus.req_addr[ADDR_WIDTH-1:0];
            funct3_r <= bus.req_funct3;
            data_r   <= bus.req_wdata;
            rdata_r  <= 32'h0000_0000;
            mis_r    <= mis_s;
            fault_r  <= fault_s;
          end
        end
        LOAD:     rdata_r <= load_val_s;
        RMW_READ: data_r  <= merged_s;
        default:  ;
      endcase
    end
  end

  // All outputs decode registered state only, so reset removes them at once.
  assign bus.req_ready      = (state_r == IDLE);
  assign bus.rsp_valid      = (state_r == RESP);
  assign bus.rsp_rdata      = bus.rsp_valid ? rdata_r : 32'h0000_0000;
  assign bus.rsp_misaligned = bus.rsp_valid & mis_r;
  assign bus.rsp_fault      = bus.rsp_valid & fault_r;
  assign mem_write_en       = (state_r == WRITE);
  assign mem_address        = addr_r;
  assign mem_data_in        = data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a behavioural data memory behind it.
// Stimulus pushes expected responses into a scoreboard queue; a monitor on
// the falling edge pops and compares every response it sees.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_write_en;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data_in;
  logic [31:0]   mem_data_out;

  logic [31:0]   mem [0:255];
  logic          bd_we;
  logic [7:0]    bd_idx;
  logic [31:0]   bd_val;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int wr_last = -1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        fault;
    logic [31:0] due;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    acc_q[$];

  load_store_unit_if bus_if();

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .mem_write_en (mem_write_en),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Data memory: combinational read, word write on the rising edge, plus a backdoor for preload.
  assign mem_data_out = mem[mem_address[AW-1:2]];
  always @(posedge clk) begin
    if (bd_we)             mem[bd_idx] <= bd_val;
    else if (mem_write_en) mem[mem_address[AW-1:2]] <= mem_data_in;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: write log, accept log and scoreboard compare on every falling edge.
  initial forever begin
    exp_t  e;
    string nm;
    @(negedge clk);
    if (mem_write_en) begin
      wr_cnt++;
      wr_last = cyc;
    end
    if (bus_if.req_valid && bus_if.req_ready) acc_q.push_back(cyc);
    if (bus_if.rsp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 in cycle %0d, required no response", cyc);
      end else begin
        e  = sb_q.pop_front();
        nm = nm_q.pop_front();
        chk({nm, "_cycle"}, cyc, e.due);
        chk({nm, "_rdata"}, bus_if.rsp_rdata, e.rdata);
        chk({nm, "_misaligned"}, {31'd0, bus_if.rsp_misaligned}, {31'd0, e.mis});
        chk({nm, "_fault"}, {31'd0, bus_if.rsp_fault}, {31'd0, e.fault});
      end
    end else if (sb_q.size() != 0 && int'(sb_q[0].due) < cyc) begin
      e  = sb_q.pop_front();
      nm = nm_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s_missing: no rsp_valid by cycle %0d, required in cycle %0d", nm, cyc, e.due);
    end
  end

  // Issue one request (called at posedge+1), then wait for its response and check writes.
  task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic emis, input logic efault,
                       input int rlat, input int ewr, input int wlat);
    int n;
    int wr0;
    int acc;
    wr0 = wr_cnt;
    bus_if.req_valid  = 1'b1;
    bus_if.req_we     = we;
    bus_if.req_funct3 = f3;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
    n = 0;
    @(negedge clk);
    while (!bus_if.req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!bus_if.req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: req_ready=0 after 20 cycles, required 1", nm);
      bus_if.req_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    sb_q.push_back('{exp_rd, emis, efault, acc + rlat});
    nm_q.push_back(nm);
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: response still pending after 20 cycles", nm);
      sb_q.delete();
      nm_q.delete();
    end
    chk({nm, "_writes"}, wr_cnt - wr0, ewr);
    if (ewr > 0) chk({nm, "_write_cycle"}, wr_last, acc + wlat);
  endtask

  initial begin
    int c;
    int wr0;
    bus_if.req_valid  = 1'b0;
    bus_if.req_we     = 1'b0;
    bus_if.req_funct3 = 3'b000;
    bus_if.req_addr   = 32'h0;
    bus_if.req_wdata  = 32'h0;
    bd_we  = 1'b1;
    bd_idx = 8'd4;
    bd_val = 32'h8899_AABB;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
    chk("reset_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
    chk("reset_write_en", {31'd0, mem_write_en}, 32'd0);
    chk("reset_mem_address", {22'd0, mem_address}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1. Loads from 0x8899AABB at 0x010.
    issue("lb_013",  1'b0, F3_B,  32'h013, 32'h0, 32'hFFFF_FF88, 1'b0, 1'b0, 2, 0, 0);
    issue("lbu_013", 1'b0, F3_BU, 32'h013, 32'h0, 32'h0000_0088, 1'b0, 1'b0, 2, 0, 0);
    issue("lhu_010", 1'b0, F3_HU, 32'h010, 32'h0, 32'h0000_AABB, 1'b0, 1'b0, 2, 0, 0);

    // 2. Byte store via read-modify-write.
    issue("sb_011", 1'b1, F3_B, 32'h011, 32'h0000_005A, 32'h0, 1'b0, 1'b0, 3, 1, 2);
    chk("sb_011_word", mem[4], 32'h8899_5ABB);

    // 3. Word store and reads back.
    issue("sw_020", 1'b1, F3_W, 32'h020, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 2, 1, 1);
    chk("sw_020_word", mem[8], 32'hDEAD_BEEF);
    issue("lw_020", 1'b0, F3_W, 32'h020, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2, 0, 0);
    issue("lh_022", 1'b0, F3_H, 32'h022, 32'h0, 32'hFFFF_DEAD, 1'b0, 1'b0, 2, 0, 0);

    // 4. Misaligned accesses.
    issue("lh_011_mis", 1'b0, F3_H, 32'h011, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0, 0);
    issue("sw_022_mis", 1'b1, F3_W, 32'h022, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 1, 0, 0);
    chk("mis_word_020", mem[8], 32'hDEAD_BEEF);

    // 5. Faults: out of range, illegal load funct3, illegal store funct3.
    issue("sw_400_fault", 1'b1, F3_W, 32'h400, 32'h1111_1111, 32'h0, 1'b0, 1'b1, 1, 0, 0);
    issue("ld_f3_011", 1'b0, 3'b011, 32'h010, 32'h0, 32'h0, 1'b0, 1'b1, 1, 0, 0);
    issue("st_f3_100", 1'b1, 3'b100, 32'h010, 32'h2222_2222, 32'h0, 1'b0, 1'b1, 1, 0, 0);
    chk("fault_word_010", mem[4], 32'h8899_5ABB);

    // Back-to-back: LW held on req_valid is taken only in IDLE, every 3 cycles.
    acc_q.delete();
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back('{32'hDEAD_BEEF, 1'b0, 1'b0, c + 3 * k + 2});
      nm_q.push_back("b2b_lw");
    end
    bus_if.req_valid  = 1'b1;
    bus_if.req_we     = 1'b0;
    bus_if.req_funct3 = F3_W;
    bus_if.req_addr   = 32'h020;
    repeat (7) @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_accepts", acc_q.size(), 32'd3);
    for (int k = 0; k < 3 && k < acc_q.size(); k++) chk("b2b_accept_cycle", acc_q[k], c + 3 * k);

    // 6. Reset during the WRITE cycle of an SH abandons the write and the response.
    wr0 = wr_cnt;
    bus_if.req_valid  = 1'b1;
    bus_if.req_we     = 1'b1;
    bus_if.req_funct3 = F3_H;
    bus_if.req_addr   = 32'h012;
    bus_if.req_wdata  = 32'h0000_BEEF;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_sh_write_en_before", {31'd0, mem_write_en}, 32'd1);
    chk("rst_sh_merged", mem_data_in, 32'hBEEF_5ABB);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_write_en_drop", {31'd0, mem_write_en}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_writes", wr_cnt - wr0, 32'd0);
    chk("rst_word_010", mem[4], 32'h8899_5ABB);
    chk("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    issue("lw_010_after_rst", 1'b0, F3_W, 32'h010, 32'h0, 32'h8899_5ABB, 1'b0, 1'b0, 2, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
